clu_sequencer: RTL
==================

Name: clu_sequencer

Overview:
- Issue/writeback controller on the driving side of the 4-bit combinational logic unit (CLU) in the MiniCPU.
- Accepts encoded instructions over a valid/ready handshake and reads operands from an internal 4x4-bit register file.
- Drives the CLU operand and control inputs, then captures the CLU result and flags into the register file and a status register.
- Returns each result over a second valid/ready handshake.

Parameters:
- NREG, 4, number of register-file entries (fixed at 4; register addresses are 2 bits).
- DW, 4, datapath width (must match the CLU).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction available
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  10  [9]=LDI, [8:6]=op, [5:4]=rd, [3:2]=ra, [1:0]=rb; when LDI=1, [3:0]=imm
- clu_a  out  4  CLU operand A (registered)
- clu_b  out  4  CLU operand B (registered)
- clu_ctrl  out  3  CLU control code (registered)
- clu_result  in  4  CLU result
- clu_zero  in  1  CLU zero flag
- clu_sign  in  1  CLU sign flag
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_data  out  4  value written to rd (0 on error)
- res_err  out  1  illegal opcode indication, qualified by res_valid
- flag_z  out  1  sticky zero status from the last legal instruction
- flag_s  out  1  sticky sign status from the last legal instruction
- dbg_addr  in  2  register-file debug read address
- dbg_data  out  4  combinational read of rf[dbg_addr]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rf[0..3]=0.
  - clu_a, clu_b, clu_ctrl, res_data = 0.
  - res_valid, res_err, flag_z, flag_s = 0.
  - Reset mid-operation abandons the instruction; no partial writeback is kept.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - instr_ready=1 (asserted only in IDLE).
  - instr_valid & instr_ready at edge E0: clu_a<=rf[ra], clu_b<=rf[rb], clu_ctrl<=op; the instruction fields are latched; go to ISSUE.
- ISSUE (exactly one cycle; the CLU settles combinationally):
  - At edge E1, go to RESP and set res_valid<=1.
  - Legal op (000..101, LDI=0): rf[rd]<=clu_result, res_data<=clu_result, flag_z<=clu_zero, flag_s<=clu_sign, res_err<=0.
  - LDI=1: the CLU is ignored. rf[rd]<=imm, res_data<=imm, flag_z<=(imm==0), flag_s<=imm[3], res_err<=0.
  - Illegal op (110/111, LDI=0): no rf write, flags unchanged, res_data<=0, res_err<=1.
- RESP:
  - res_valid held with res_data and res_err stable until res_ready=1.
  - On the accepting edge: res_valid<=0, res_err<=0, go to IDLE.
- Throughput and latency:
  - Minimum 3 cycles per instruction when res_ready is held high.
  - Result latency is 1 edge after accept (res_valid visible after E1).
- Hazards:
  - ra or rb equal to the previous rd reads the updated value; the writeback at E1 precedes the next accept.
  - rd==ra==rb is legal.
- Outputs are registered except instr_ready (decoded from state) and dbg_data.
- A res_ready pulse outside RESP is ignored.

Optional Feature:
- Macro: CLU_SEQ_PERF_EN
- Defined:
  - Extra outputs: perf_cnt[7:0] and perf_err[7:0], both reset to 0.
  - perf_cnt increments at every E1; perf_err increments at E1 on illegal ops.
  - Both counters wrap 255->0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then LDI r1=4'b1010 and LDI r2=4'b0110 -> res_data 1010 (flag_s=1), then 0110 (flag_z=0, flag_s=0); dbg r1=1010, r2=0110.
- Sweep AND/OR/XOR/NOR on rd=r3, ra=r1, rb=r2 -> clu_ctrl 000..011, results 0010/1110/1100/0001; flags follow clu_zero/clu_sign.
- XOR r0=r1^r1 -> res_data 0000, flag_z=1; then SHL r3=r2<<1 (0110) -> 1100, flag_s=1; SHR r3=r2>>1 -> 0011.
- op=110 with rd=r1 -> res_err=1, res_data=0, r1 unchanged, flag_z/flag_s unchanged; the next legal op clears res_err.
- Hold res_ready=0 for 5 cycles in RESP -> res_valid and res_data stable, instr_ready=0; an offered instruction is not accepted until after the response handshake.
- Drop rst_n during ISSUE of a write to r2 -> r2=0, all outputs 0, state IDLE. Back-to-back instructions with res_ready=1 -> exactly 3 cycles each; perf_cnt counts correctly when CLU_SEQ_PERF_EN is defined.

Source files
------------

// File: rtl/clu_sequencer.sv
// Issue/writeback sequencer driving the 4-bit CLU of the MiniCPU: instruction in, operands out, result captured back.
// Optional build macro CLU_SEQ_PERF_EN adds perf_cnt/perf_err instruction and illegal-op counters.
module clu_sequencer #(
    parameter int NREG = 4,
    parameter int DW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [9:0]    instr,
    output logic [DW-1:0] clu_a,
    output logic [DW-1:0] clu_b,
    output logic [2:0]    clu_ctrl,
    input  logic [DW-1:0] clu_result,
    input  logic          clu_zero,
    input  logic          clu_sign,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_err,
    output logic          flag_z,
    output logic          flag_s,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [1:0]    dbg_state
`ifdef CLU_SEQ_PERF_EN
    ,
    output logic [7:0]    perf_cnt,
    output logic [7:0]    perf_err
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the sender holds valid and its payload stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic          ldi_q;
    logic [2:0]    op_q;
    logic [1:0]    rd_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] clu_a_q, clu_b_q;
    logic [2:0]    clu_ctrl_q;
    logic [DW-1:0] res_data_q;
    logic          res_valid_q, res_err_q, flag_z_q, flag_s_q;

    logic          accept, issue, resp_done;
    logic          illegal;
    logic [DW-1:0] wb_data;
    logic          wb_z, wb_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = S_RESP;
            S_RESP:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        accept      = (state_q == S_IDLE) && instr_valid;
        issue       = (state_q == S_ISSUE);
        resp_done   = (state_q == S_RESP) && res_ready;
    end

    // LDI bypasses the CLU entirely; opcodes 110/111 are unassigned in the CLU.
    always_comb begin
        illegal = !ldi_q && (op_q[2:1] == 2'b11);
        wb_data = ldi_q ? imm_q : clu_result;
        wb_z    = ldi_q ? (imm_q == '0) : clu_zero;
        wb_s    = ldi_q ? imm_q[DW-1] : clu_sign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldi_q      <= 1'b0;
            op_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            clu_a_q    <= '0;
            clu_b_q    <= '0;
            clu_ctrl_q <= '0;
        end else if (accept) begin
            ldi_q      <= instr[9];
            op_q       <= instr[8:6];
            rd_q       <= instr[5:4];
            imm_q      <= instr[3:0];
            clu_a_q    <= rf_q[instr[3:2]];
            clu_b_q    <= rf_q[instr[1:0]];
            clu_ctrl_q <= instr[8:6];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (issue && !illegal) begin
            rf_q[rd_q] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
            flag_z_q    <= 1'b0;
            flag_s_q    <= 1'b0;
        end else if (issue) begin
            res_valid_q <= 1'b1;
            res_err_q   <= illegal;
            res_data_q  <= illegal ? '0 : wb_data;
            if (!illegal) begin
                flag_z_q <= wb_z;
                flag_s_q <= wb_s;
            end
        end else if (resp_done) begin
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
        end
    end

`ifdef CLU_SEQ_PERF_EN
    logic [7:0] perf_cnt_q, perf_err_q;

    // Both counters wrap naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
            perf_err_q <= '0;
        end else if (issue) begin
            perf_cnt_q <= perf_cnt_q + 8'd1;
            if (illegal) begin
                perf_err_q <= perf_err_q + 8'd1;
            end
        end
    end

    assign perf_cnt = perf_cnt_q;
    assign perf_err = perf_err_q;
`endif

    assign clu_a     = clu_a_q;
    assign clu_b     = clu_b_q;
    assign clu_ctrl  = clu_ctrl_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign flag_z    = flag_z_q;
    assign flag_s    = flag_s_q;
    assign dbg_data  = rf_q[dbg_addr];
    assign dbg_state = state_q;

endmodule
